// File: rtl/decode_queue.sv
// Decode stage: extracts opcode/rd/rs/sign-extended immediate from fetched instructions into a 2-entry FIFO.
// Optional length check on accept is enabled by defining DECODE_LEN_CHECK_EN.
module decode_queue #(
    parameter int                       MAX_INSTR_WIDTH = 64,
    parameter int                       DATA_WIDTH      = 32,
    parameter int                       ADDRESS_WIDTH   = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [MAX_INSTR_WIDTH-1:0] i_instr,
    input  logic [3:0]                 i_instr_len,
    input  logic                       i_flush,
    input  logic [ADDRESS_WIDTH-1:0]   i_flush_pc,
    output logic                       o_res_valid,
    input  logic                       i_res_ready,
    output logic [ADDRESS_WIDTH-1:0]   o_pc,
    output logic [7:0]                 o_opcode,
    output logic [3:0]                 o_rd,
    output logic [3:0]                 o_rs,
    output logic [DATA_WIDTH-1:0]      o_imm,
    output logic [3:0]                 o_len,
    output logic                       o_illegal
);

    // state | meaning
    // EMPTY | no decoded entry held
    // ONE   | head entry valid, tail free
    // TWO   | head and tail valid, input stalled
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [7:0]               opcode;
        logic [3:0]               rd;
        logic [3:0]               rs;
        logic [DATA_WIDTH-1:0]    imm;
        logic [3:0]               len;
        logic                     illegal;
    } entry_t;

    localparam int NUM_BYTES = MAX_INSTR_WIDTH / 8;
    localparam int PAD_W     = 128;

    state_t                   state, state_next;
    entry_t                   head, tail, decoded;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic                     accept, pop;
    logic                     load_head, load_tail, shift_tail;

    logic [PAD_W-1:0]         instr_pad;
    logic [DATA_WIDTH-1:0]    imm_src;
    logic [DATA_WIDTH-1:0]    imm_ext;
    logic [3:0]               len_m1;
    logic [6:0]               len_bits;
    logic                     sign;

    assign o_ready     = (state != TWO);
    assign o_res_valid = (state != EMPTY);
    assign accept      = i_valid && o_ready;
    assign pop         = o_res_valid && i_res_ready;

    // Bytes past the instruction width (len can reach 15) read as zero.
    always_comb begin
        instr_pad = PAD_W'(i_instr);
        imm_src   = DATA_WIDTH'(instr_pad >> 16);
        len_m1    = i_instr_len - 4'd1;
        len_bits  = {i_instr_len, 3'b000};
        sign      = instr_pad[{len_m1, 3'b111}];
        imm_ext   = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            imm_ext[i] = (i + 16 < int'(len_bits)) ? imm_src[i] : sign;
        end
    end

    always_comb begin
        decoded         = '0;
        decoded.pc      = pc;
        decoded.opcode  = instr_pad[7:0];
        decoded.len     = i_instr_len;
        if (i_instr_len >= 4'd2) begin
            decoded.rd = instr_pad[11:8];
            decoded.rs = instr_pad[15:12];
        end
        if (i_instr_len > 4'd2) begin
            decoded.imm = imm_ext;
        end
`ifdef DECODE_LEN_CHECK_EN
        if ((i_instr_len == 4'd0) || (int'(i_instr_len) > NUM_BYTES)) begin
            decoded.illegal = 1'b1;
            decoded.rd      = '0;
            decoded.rs      = '0;
            decoded.imm     = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_head  = 1'b0;
        load_tail  = 1'b0;
        shift_tail = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = ONE;
                    load_head  = 1'b1;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    load_head = 1'b1;
                end else if (accept) begin
                    state_next = TWO;
                    load_tail  = 1'b1;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_next = ONE;
                    shift_tail = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Redirect wins: nothing is written, queue empties.
        if (i_flush) begin
            state_next = EMPTY;
            load_head  = 1'b0;
            load_tail  = 1'b0;
            shift_tail = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            head.pc <= RESET_PC;
            tail    <= '0;
            pc      <= RESET_PC;
        end else begin
            if (i_flush) begin
                pc <= i_flush_pc;
            end else if (accept) begin
                pc <= pc + ADDRESS_WIDTH'(i_instr_len);
            end
            if (load_head) begin
                head <= decoded;
            end else if (shift_tail) begin
                head <= tail;
            end
            if (load_tail) begin
                tail <= decoded;
            end
        end
    end

    assign o_pc      = head.pc;
    assign o_opcode  = head.opcode;
    assign o_rd      = head.rd;
    assign o_rs      = head.rs;
    assign o_imm     = head.imm;
    assign o_len     = head.len;
    assign o_illegal = head.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: decode vector table, hand-written handshake/flush/wrap sequences,
// then random traffic against a queue-based reference model.
module tb_decode_queue;
    localparam logic [31:0] RPC = 32'h100;

    logic        clk = 1'b0;
    logic        reset, i_valid, o_ready, i_flush, i_res_ready, o_res_valid, o_illegal;
    logic [63:0] i_instr;
    logic [3:0]  i_instr_len, o_rd, o_rs, o_len;
    logic [31:0] i_flush_pc, o_pc, o_imm;
    logic [7:0]  o_opcode;

    always #5 clk = ~clk;

    decode_queue #(
        .MAX_INSTR_WIDTH(64), .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .RESET_PC(RPC)
    ) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_instr(i_instr), .i_instr_len(i_instr_len), .i_flush(i_flush),
        .i_flush_pc(i_flush_pc), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_pc(o_pc), .o_opcode(o_opcode), .o_rd(o_rd), .o_rs(o_rs), .o_imm(o_imm),
        .o_len(o_len), .o_illegal(o_illegal)
    );

    typedef struct {
        logic [31:0] pc;
        logic [7:0]  opcode;
        logic [3:0]  rd, rs;
        logic [31:0] imm;
        logic [3:0]  len;
        logic        illegal;
    } ent_t;

    typedef struct {
        logic [63:0] instr;
        logic [3:0]  len;
        logic [7:0]  op;
        logic [3:0]  rd, rs;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    int   vectors = 0, miscompares = 0;
    vec_t tbl[10];
    ent_t mq[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_head(string tag, ent_t e);
        check({tag, " valid"},   o_res_valid, 1'b1);
        check({tag, " pc"},      o_pc,        e.pc);
        check({tag, " opcode"},  o_opcode,    e.opcode);
        check({tag, " rd"},      o_rd,        e.rd);
        check({tag, " rs"},      o_rs,        e.rs);
        check({tag, " imm"},     o_imm,       e.imm);
        check({tag, " len"},     o_len,       e.len);
        check({tag, " illegal"}, o_illegal,   e.illegal);
    endtask

    // Reference decode built from byte arithmetic on the instruction.
    function automatic ent_t ref_decode(logic [31:0] pc, logic [63:0] instr, logic [3:0] len);
        ent_t         e;
        logic [7:0]   b[16];
        logic [127:0] v;
        int           nb;
        for (int k = 0; k < 16; k++) b[k] = 8'(instr >> (8 * k));
        e.pc = pc; e.len = len; e.opcode = b[0];
        e.rd = '0; e.rs = '0; e.imm = '0; e.illegal = 1'b0;
        if (len >= 2) begin
            e.rd = b[1][3:0];
            e.rs = b[1][7:4];
        end
        if (len > 2) begin
            v = '0;
            for (int k = 2; k < int'(len); k++) v = v | (128'(b[k]) << (8 * (k - 2)));
            nb = 8 * (int'(len) - 2);
            if (v[nb - 1]) v = v | ~((128'd1 << nb) - 128'd1);
            e.imm = v[31:0];
        end
`ifdef DECODE_LEN_CHECK_EN
        if (len == 0 || len > 8) begin
            e.illegal = 1'b1; e.rd = '0; e.rs = '0; e.imm = '0;
        end
`endif
        return e;
    endfunction

    task automatic do_reset();
        reset = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_res_ready = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic offer(logic [63:0] instr, logic [3:0] len);
        i_valid = 1'b1; i_instr = instr; i_instr_len = len;
    endtask

    initial begin
        ent_t        e;
        logic [31:0] exp_pc;
        logic [31:0] pcs[4];
        logic [3:0]  lens[4];
        logic        acc, pp;

        tbl[0] = '{64'h0000_0000_00F0_2107, 4'd3, 8'h07, 4'h1, 4'h2, 32'hFFFF_FFF0, 1'b0};
        tbl[1] = '{64'h1122_3344_5566_7788, 4'd1, 8'h88, 4'h0, 4'h0, 32'h0,         1'b0};
        tbl[2] = '{64'h1122_3344_5566_7788, 4'd2, 8'h88, 4'h7, 4'h7, 32'h0,         1'b0};
        tbl[3] = '{64'h1122_3344_5566_7788, 4'd4, 8'h88, 4'h7, 4'h7, 32'h0000_5566, 1'b0};
        tbl[4] = '{64'h0000_0000_8001_A5C3, 4'd4, 8'hC3, 4'h5, 4'hA, 32'hFFFF_8001, 1'b0};
        tbl[5] = '{64'h0000_1234_5678_9ABC, 4'd6, 8'hBC, 4'hA, 4'h9, 32'h1234_5678, 1'b0};
        tbl[6] = '{64'h8000_0000_1234_0000, 4'd8, 8'h00, 4'h0, 4'h0, 32'h0000_1234, 1'b0};
        tbl[7] = '{64'h00AB_CDEF_0123_4567, 4'd7, 8'h67, 4'h5, 4'h4, 32'hCDEF_0123, 1'b0};
`ifdef DECODE_LEN_CHECK_EN
        tbl[8] = '{64'h0000_0000_00FF_FF5A, 4'd0, 8'h5A, 4'h0, 4'h0, 32'h0,         1'b1};
        tbl[9] = '{64'h8000_0000_0001_3412, 4'd9, 8'h12, 4'h0, 4'h0, 32'h0,         1'b1};
`else
        tbl[8] = '{64'h0000_0000_00FF_FF5A, 4'd0, 8'h5A, 4'h0, 4'h0, 32'h0,         1'b0};
        tbl[9] = '{64'h8000_0000_0001_3412, 4'd9, 8'h12, 4'h4, 4'h3, 32'h0000_0001, 1'b0};
`endif

        i_instr = '0; i_instr_len = '0; i_flush_pc = '0;
        @(negedge clk);

        // Reset values, sampled while reset is still asserted.
        reset = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_res_ready = 1'b0;
        step();
        check("rst valid", o_res_valid, 1'b0);
        check("rst ready", o_ready, 1'b1);
        check("rst pc", o_pc, RPC);
        check("rst opcode", o_opcode, 8'h0);
        check("rst rd", o_rd, 4'h0);
        check("rst rs", o_rs, 4'h0);
        check("rst imm", o_imm, 32'h0);
        check("rst len", o_len, 4'h0);
        check("rst illegal", o_illegal, 1'b0);
        reset = 1'b0;

        // Single instruction, one-cycle latency, popped next cycle.
        i_res_ready = 1'b1;
        offer(64'hFFFF_FFFF_FFF0_2107, 4'd3);
        step();
        i_valid = 1'b0;
        e = '{32'h100, 8'h07, 4'h1, 4'h2, 32'hFFFF_FFF0, 4'd3, 1'b0};
        check_head("single", e);
        step();
        check("single drained", o_res_valid, 1'b0);

        // Streaming with consumer always ready.
        do_reset();
        i_res_ready = 1'b1;
        lens = '{4'd2, 4'd3, 4'd4, 4'd1};
        pcs  = '{32'h100, 32'h102, 32'h105, 32'h109};
        for (int i = 0; i < 4; i++) begin
            check("stream ready", o_ready, 1'b1);
            offer(64'(i) << 8, lens[i]);
            step();
            check("stream valid", o_res_valid, 1'b1);
            check("stream pc", o_pc, pcs[i]);
        end
        i_valid = 1'b0;
        step();
        check("stream drained", o_res_valid, 1'b0);

        // Backpressure: two accepted, third held until after first pop.
        do_reset();
        offer(64'h00A1, 4'd1);
        step();
        check("bp ready after 1", o_ready, 1'b1);
        offer(64'h00B2, 4'd1);
        step();
        check("bp ready after 2", o_ready, 1'b0);
        offer(64'h00C3, 4'd1);
        step();
        check("bp ready held", o_ready, 1'b0);
        check("bp head op", o_opcode, 8'hA1);
        check("bp head pc", o_pc, 32'h100);
        i_res_ready = 1'b1;
        step();
        check("bp ready after pop", o_ready, 1'b1);
        check("bp second op", o_opcode, 8'hB2);
        check("bp second pc", o_pc, 32'h101);
        step();
        i_valid = 1'b0;
        check("bp third op", o_opcode, 8'hC3);
        check("bp third pc", o_pc, 32'h102);
        step();
        check("bp drained", o_res_valid, 1'b0);

        // Flush from TWO with an instruction offered in the same cycle.
        i_res_ready = 1'b0;
        offer(64'h0011, 4'd1); step();
        offer(64'h0022, 4'd1); step();
        check("fl full", o_ready, 1'b0);
        i_flush = 1'b1; i_flush_pc = 32'h2000; offer(64'h00EE, 4'd2);
        step();
        i_flush = 1'b0; i_valid = 1'b0;
        check("fl valid", o_res_valid, 1'b0);
        check("fl ready", o_ready, 1'b1);
        i_res_ready = 1'b1;
        offer(64'h0055, 4'd2);
        step();
        i_valid = 1'b0;
        check("fl op", o_opcode, 8'h55);
        check("fl pc", o_pc, 32'h2000);

        // Flush while ready drops the offered instruction; then PC wrap.
        i_flush = 1'b1; i_flush_pc = 32'hFFFF_FFFE; offer(64'h0099, 4'd1);
        step();
        i_flush = 1'b0;
        check("wrap flush valid", o_res_valid, 1'b0);
        offer(64'h0033, 4'd4);
        step();
        check("wrap pc0", o_pc, 32'hFFFF_FFFE);
        offer(64'h0044, 4'd1);
        step();
        i_valid = 1'b0;
        check("wrap pc1", o_pc, 32'h0000_0002);
        check("wrap op1", o_opcode, 8'h44);

        // Decode table, streamed from a known PC.
        i_flush = 1'b1; i_flush_pc = 32'h1000;
        step();
        i_flush = 1'b0;
        exp_pc = 32'h1000;
        for (int i = 0; i < 10; i++) begin
            offer(tbl[i].instr, tbl[i].len);
            step();
            e = '{exp_pc, tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].imm, tbl[i].len, tbl[i].ill};
            check_head($sformatf("tbl%0d", i), e);
            exp_pc = exp_pc + 32'(tbl[i].len);
        end
        i_valid = 1'b0;
        step();

        // Random traffic against the queue model.
        do_reset();
        exp_pc = RPC;
        mq.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check("rnd valid", o_res_valid, mq.size() != 0);
            check("rnd ready", o_ready, mq.size() < 2);
            if (mq.size() != 0) check_head("rnd", mq[0]);
            i_valid     = ($urandom_range(0, 3) != 0);
            i_instr     = {$urandom, $urandom};
            i_instr_len = 4'($urandom_range(0, 15));
            i_res_ready = ($urandom_range(0, 2) != 0);
            i_flush     = ($urandom_range(0, 24) == 0);
            i_flush_pc  = $urandom;
            if (i_flush) begin
                mq.delete();
                exp_pc = i_flush_pc;
            end else begin
                acc = i_valid && (mq.size() < 2);
                pp  = i_res_ready && (mq.size() != 0);
                if (pp) void'(mq.pop_front());
                if (acc) begin
                    mq.push_back(ref_decode(exp_pc, i_instr, i_instr_len));
                    exp_pc = exp_pc + 32'(i_instr_len);
                end
            end
            step();
        end

        // Reset in the middle of traffic overrides a flush request.
        i_valid = 1'b1; i_flush = 1'b1; i_flush_pc = 32'h5555; reset = 1'b1;
        step();
        reset = 1'b0; i_valid = 1'b0; i_flush = 1'b0;
        check("midrst valid", o_res_valid, 1'b0);
        check("midrst pc", o_pc, RPC);
        i_res_ready = 1'b1;
        offer(64'h0077, 4'd1);
        step();
        i_valid = 1'b0;
        check("midrst next pc", o_pc, RPC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
